ama_riscv_load_align: RTL

- DMEM load-return path; the read-side counterpart of the store byte-mask logic.
- Captures load request attributes (offset, width, destination register) in the cycle the load is issued to DMEM.
- Aligns and sign- or zero-extends the synchronous DMEM read data returned one cycle later, and presents a registered writeback result.
- Includes a one-entry hold buffer so that read data returning during a pipeline stall is not lost.

---
 rtl/ama_riscv_load_align.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ama_riscv_load_align.sv
// DMEM load-return path: captures load attributes at issue, aligns and extends
// the synchronous read word one cycle later, and buffers it across a stall.
//
// state | meaning
// IDLE  | no response pending
// RESP  | stage valid, dmem_rdata is valid this cycle
// HOLD  | aligned result buffered, waiting for stall to drop
module ama_riscv_load_align #(
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_en,
    input  logic [1:0]      req_offset,
    input  logic [2:0]      req_width,
    input  logic [RD_W-1:0] req_rd,
    input  logic            stall,
    input  logic            flush,
    input  logic [31:0]     dmem_rdata,
    output logic [31:0]     ld_data,
    output logic [RD_W-1:0] ld_rd,
    output logic            ld_valid,
    output logic            ld_err,
    output logic            busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [2:0] W_LB  = 3'b000;
    localparam logic [2:0] W_LH  = 3'b001;
    localparam logic [2:0] W_LW  = 3'b010;
    localparam logic [2:0] W_LBU = 3'b100;
    localparam logic [2:0] W_LHU = 3'b101;

    state_t          state_q, state_d;

    logic [1:0]      stg_off_q, stg_off_d;
    logic [2:0]      stg_wid_q, stg_wid_d;
    logic [RD_W-1:0] stg_rd_q,  stg_rd_d;

    logic [31:0]     hold_data_q, hold_data_d;
    logic            hold_err_q,  hold_err_d;
    logic [RD_W-1:0] hold_rd_q,   hold_rd_d;

    logic [31:0]     out_data_q,  out_data_d;
    logic            out_err_q,   out_err_d;
    logic [RD_W-1:0] out_rd_q,    out_rd_d;
    logic            out_valid_q, out_valid_d;

    logic [31:0]     shifted;
    logic [7:0]      al_byte;
    logic [15:0]     al_half;
    logic [31:0]     al_data;
    logic            al_err;

    // Alignment is a shift by the byte offset; a faulting load reports zero data.
    always_comb begin
        shifted = dmem_rdata >> {stg_off_q, 3'b000};
        al_byte = shifted[7:0];
        al_half = shifted[15:0];
        al_data = '0;
        al_err  = 1'b0;
        case (stg_wid_q)
            W_LB:  al_data = {{24{al_byte[7]}}, al_byte};
            W_LBU: al_data = {24'd0, al_byte};
            W_LH: begin
                if (stg_off_q == 2'd3) al_err = 1'b1;
                else                   al_data = {{16{al_half[15]}}, al_half};
            end
            W_LHU: begin
                if (stg_off_q == 2'd3) al_err = 1'b1;
                else                   al_data = {16'd0, al_half};
            end
            W_LW: begin
                if (stg_off_q != 2'd0) al_err = 1'b1;
                else                   al_data = dmem_rdata;
            end
            default: al_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        stg_off_d   = stg_off_q;
        stg_wid_d   = stg_wid_q;
        stg_rd_d    = stg_rd_q;
        hold_data_d = hold_data_q;
        hold_err_d  = hold_err_q;
        hold_rd_d   = hold_rd_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        out_rd_d    = out_rd_q;
        out_valid_d = out_valid_q;

        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else if (stall) begin
            // Read data is only valid in the response cycle, so park it now.
            if (state_q == ST_RESP) begin
                hold_data_d = al_data;
                hold_err_d  = al_err;
                hold_rd_d   = stg_rd_q;
                state_d     = ST_HOLD;
            end
        end else begin
            case (state_q)
                ST_RESP: begin
                    out_data_d  = al_data;
                    out_err_d   = al_err;
                    out_rd_d    = stg_rd_q;
                    out_valid_d = 1'b1;
                end
                ST_HOLD: begin
                    out_data_d  = hold_data_q;
                    out_err_d   = hold_err_q;
                    out_rd_d    = hold_rd_q;
                    out_valid_d = 1'b1;
                end
                default: out_valid_d = 1'b0;
            endcase
            stg_off_d = req_offset;
            stg_wid_d = req_width;
            stg_rd_d  = req_rd;
            state_d   = req_en ? ST_RESP : ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            stg_off_q   <= '0;
            stg_wid_q   <= '0;
            stg_rd_q    <= '0;
            hold_data_q <= '0;
            hold_err_q  <= 1'b0;
            hold_rd_q   <= '0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            out_rd_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stg_off_q   <= stg_off_d;
            stg_wid_q   <= stg_wid_d;
            stg_rd_q    <= stg_rd_d;
            hold_data_q <= hold_data_d;
            hold_err_q  <= hold_err_d;
            hold_rd_q   <= hold_rd_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            out_rd_q    <= out_rd_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ld_data  = out_data_q;
    assign ld_rd    = out_rd_q;
    assign ld_valid = out_valid_q;
    assign ld_err   = out_err_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
